// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire NRZ receiver.
// Measures the width of each high pulse on the synchronised data line and
// decodes it as a 0 or 1 bit. Every 24 bits form one GRB pixel. A long low
// level ends the frame.
// Optional build macro WS2812B_RX_FILTER_EN inserts a 3-sample majority glitch
// filter after the synchroniser. This rejects 1-cycle line pulses and adds
// 2 cycles to every latency.
module ws2812b_rx #(
    parameter int unsigned MIN_HIGH_CNT   = 4,
    parameter int unsigned BIT_THRESH_CNT = 17,
    parameter int unsigned MAX_HIGH_CNT   = 40,
    parameter int unsigned RESET_CNT      = 1350,
    parameter int unsigned IDX_W          = 10
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             ws_in,
    output logic             pixel_valid,
    output logic [7:0]       Red,
    output logic [7:0]       Green,
    output logic [7:0]       Blue,
    output logic [IDX_W-1:0] pixel_idx,
    output logic             frame_end,
    output logic             err,
    output logic             busy
);

    localparam int unsigned HCNT_W = $clog2(MAX_HIGH_CNT + 1);
    localparam int unsigned LCNT_W = $clog2(RESET_CNT + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic              line;
    logic              line_d;
    logic              rise;
    logic              fall;
    logic              bit_in;
    logic [23:0]       sr_shift;
    logic [22:0]       sr;
    logic [4:0]        bit_cnt;
    logic [HCNT_W-1:0] high_cnt;
    logic [LCNT_W-1:0] low_cnt;
    logic [IDX_W-1:0]  pix_cnt;

    // Two-flop synchroniser for the asynchronous data line
    always_ff @(posedge Clock) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ws_in;
            s2 <= s1;
        end
    end

`ifdef WS2812B_RX_FILTER_EN
    logic s2_h1;
    logic s2_h2;
    logic filt;
    logic filt_d;

    // Majority of the last three synchronised samples, plus its delayed copy
    always_ff @(posedge Clock) begin
        if (rst) begin
            s2_h1  <= 1'b0;
            s2_h2  <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            s2_h1  <= s2;
            s2_h2  <= s2_h1;
            filt   <= (s2 & s2_h1) | (s2 & s2_h2) | (s2_h1 & s2_h2);
            filt_d <= filt;
        end
    end

    assign line   = filt;
    assign line_d = filt_d;
`else
    logic s2_d;

    // Delayed copy of the synchronised line for edge detection
    always_ff @(posedge Clock) begin
        if (rst) begin
            s2_d <= 1'b0;
        end else begin
            s2_d <= s2;
        end
    end

    assign line   = s2;
    assign line_d = s2_d;
`endif

    assign rise     = line & ~line_d;
    assign fall     = ~line & line_d;
    assign bit_in   = (high_cnt >= HCNT_W'(BIT_THRESH_CNT));
    assign sr_shift = {sr, bit_in};

    // Pulse-width decoder FSM with registered strobes and pixel outputs
    always_ff @(posedge Clock) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            pix_cnt     <= '0;
            pixel_valid <= 1'b0;
            Red         <= '0;
            Green       <= '0;
            Blue        <= '0;
            pixel_idx   <= '0;
            frame_end   <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HCNT_W'(1);
                        busy     <= 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= LCNT_W'(1);
                        if (high_cnt < HCNT_W'(MIN_HIGH_CNT)) begin
                            err     <= 1'b1;
                            bit_cnt <= '0;
                        end else if (bit_cnt == 5'd23) begin
                            sr          <= sr_shift[22:0];
                            bit_cnt     <= '0;
                            Green       <= sr_shift[23:16];
                            Red         <= sr_shift[15:8];
                            Blue        <= sr_shift[7:0];
                            pixel_valid <= 1'b1;
                            pixel_idx   <= pix_cnt;
                            if (pix_cnt != '1) begin
                                pix_cnt <= pix_cnt + IDX_W'(1);
                            end
                        end else begin
                            sr      <= sr_shift[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (high_cnt >= HCNT_W'(MAX_HIGH_CNT)) begin
                        state   <= ERR;
                        err     <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        high_cnt <= high_cnt + HCNT_W'(1);
                    end
                end
                ERR: begin
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= LCNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HCNT_W'(1);
                    end else if (low_cnt == LCNT_W'(RESET_CNT)) begin
                        state     <= IDLE;
                        frame_end <= 1'b1;
                        busy      <= 1'b0;
                        if (bit_cnt != '0) begin
                            err <= 1'b1;
                        end
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                    end else begin
                        low_cnt <= low_cnt + LCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx: directed bench for ws2812b_rx.
// The whole line waveform is built first. A run-length model then derives the
// expected output on every cycle. One loop drives the line and compares all
// outputs each cycle. Literal pixel and event expectations pin the model.
module tb_ws2812b_rx;

    localparam int unsigned IDX_W     = 10;
    localparam int unsigned MIN_HIGH  = 4;
    localparam int unsigned THRESH    = 17;
    localparam int unsigned MAX_HIGH  = 40;
    localparam int unsigned RESET_CNT = 1350;
    localparam int unsigned PIX_MAX   = (1 << IDX_W) - 1;
`ifdef WS2812B_RX_FILTER_EN
    localparam int unsigned LAT = 5;
`else
    localparam int unsigned LAT = 3;
`endif
    localparam int unsigned NMAX   = 40000;
    localparam int unsigned N_PIX  = 10;

    logic             Clock = 1'b0;
    logic             rst   = 1'b1;
    logic             ws_in = 1'b0;
    logic             pixel_valid;
    logic [7:0]       Red;
    logic [7:0]       Green;
    logic [7:0]       Blue;
    logic [IDX_W-1:0] pixel_idx;
    logic             frame_end;
    logic             err;
    logic             busy;

    ws2812b_rx #(.IDX_W(IDX_W)) dut (
        .Clock       (Clock),
        .rst         (rst),
        .ws_in       (ws_in),
        .pixel_valid (pixel_valid),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .pixel_idx   (pixel_idx),
        .frame_end   (frame_end),
        .err         (err),
        .busy        (busy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned      cyc;
        logic [23:0]      grb;
        logic [IDX_W-1:0] idx;
    } pix_t;

    bit               stim_line [NMAX];
    bit               stim_rst  [NMAX];
    int unsigned      n_drv;
    bit               e_pv [NMAX];
    bit               e_fe [NMAX];
    bit               e_err [NMAX];
    bit               e_on [NMAX];
    bit               e_off [NMAX];
    bit               e_rst [NMAX];
    logic [23:0]      e_grb [NMAX];
    logic [IDX_W-1:0] e_idx [NMAX];
    int               checks;
    int               failures;
    pix_t             got_q [$];
    int unsigned      fe_q [$];
    int unsigned      err_q [$];
    int unsigned      both_cnt;

    task automatic put(input bit v, input bit r, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            stim_line[n_drv] = v;
            stim_rst[n_drv]  = r;
            n_drv++;
        end
    endtask

    task automatic put_pulse(input int unsigned h, input int unsigned period);
        put(1'b1, 1'b0, h);
        put(1'b0, 1'b0, period - h);
    endtask

    task automatic put_bits(input logic [23:0] grb, input int unsigned nbits,
                            input int unsigned h0, input int unsigned h1);
        for (int unsigned k = 0; k < nbits; k++) begin
            put_pulse(grb[23 - k] ? h1 : h0, 34);
        end
    endtask

    task automatic put_pixel(input logic [23:0] grb);
        put_bits(grb, 24, 11, 23);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Decodes the line waveform run by run into per-cycle expected events
    task automatic build_model();
        bit          idle;
        int unsigned bits;
        int unsigned pix;
        logic [23:0] sh;
        int unsigned run_start;
        bit          prev;
        bit          cur;
        int unsigned len;
        int unsigned c;
        idle = 1'b1; bits = 0; pix = 0; sh = '0; run_start = 0; prev = 1'b0;
        e_rst[0] = 1'b1;
        for (int unsigned i = 0; i <= n_drv; i++) begin
            if (i < n_drv && stim_rst[i]) begin
                idle = 1'b1; bits = 0; pix = 0;
                e_rst[i + 1] = 1'b1;
            end
            cur = (i < n_drv) ? stim_line[i] : ~prev;
            if (cur != prev) begin
                len = i - run_start;
                if (prev) begin
                    if (idle) begin
                        idle = 1'b0;
                        e_on[run_start + LAT] = 1'b1;
                    end
                    if (len > MAX_HIGH) begin
                        e_err[run_start + MAX_HIGH + LAT] = 1'b1;
                        bits = 0;
                    end else if (len < MIN_HIGH) begin
                        e_err[i + LAT] = 1'b1;
                        bits = 0;
                    end else begin
                        sh = {sh[22:0], (len >= THRESH)};
                        bits++;
                        if (bits == 24) begin
                            c = i + LAT;
                            e_pv[c]  = 1'b1;
                            e_grb[c] = sh;
                            e_idx[c] = IDX_W'(pix);
                            if (pix < PIX_MAX) pix++;
                            bits = 0;
                        end
                    end
                end else if (!idle && len > RESET_CNT) begin
                    c = run_start + RESET_CNT + LAT;
                    e_fe[c]  = 1'b1;
                    e_off[c] = 1'b1;
                    if (bits != 0) e_err[c] = 1'b1;
                    bits = 0; pix = 0; idle = 1'b1;
                end
                run_start = i;
                prev      = cur;
            end
        end
    endtask

    initial begin
        logic [23:0]      h_grb;
        logic [IDX_W-1:0] h_idx;
        bit               h_busy;
        logic [37:0]      got_v;
        logic [37:0]      exp_v;
        logic [23:0]      lit_grb [N_PIX];
        int unsigned      lit_idx [N_PIX];
        pix_t             p;

        checks = 0; failures = 0; n_drv = 0; both_cnt = 0;
        h_grb = '0; h_idx = '0; h_busy = 1'b0;
        lit_grb = '{24'hA53CF0, 24'h123456, 24'h80017F, 24'hFFFFFF, 24'h5A5A5A,
                    24'h555555, 24'h0FF00F, 24'hC3C3C3, 24'h13579B, 24'hDEAD42};
        lit_idx = '{0, 0, 1, 2, 0, 0, 1, 2, 0, 0};

        // Reset, then idle line
        put(1'b0, 1'b1, 4);
        put(1'b0, 1'b0, 10);
        // One pixel and latch
        put_pixel(24'hA53CF0);
        put(1'b0, 1'b0, 1400);
        // Three pixels in one frame, latch, then a second frame
        put_pixel(24'h123456);
        put_pixel(24'h80017F);
        put_pixel(24'hFFFFFF);
        put(1'b0, 1'b0, 1400);
        put_pixel(24'h5A5A5A);
        put(1'b0, 1'b0, 1400);
        // Threshold boundary 16/17, minimum-width zeros, then a 3-cycle glitch
        for (int unsigned k = 0; k < 24; k++) put_pulse((k % 2 == 1) ? 17 : 16, 34);
        put_bits(24'h0FF00F, 24, 4, 23);
        put_bits(24'hFFFFFF, 5, 11, 23);
        put_pulse(3, 34);
        put_pixel(24'hC3C3C3);
        put(1'b0, 1'b0, 1400);
        // Stuck high mid-pixel, then a full pixel
        put_bits(24'hFFFFFF, 10, 11, 23);
        put_pulse(60, 80);
        put_pixel(24'h13579B);
        put(1'b0, 1'b0, 1400);
        // Partial frame of 12 bits
        put_bits(24'hABCDEF, 12, 11, 23);
        put(1'b0, 1'b0, 1400);
        // Reset after 20 bits, then a full pixel
        put_bits(24'hFFFFFF, 20, 11, 23);
        put(1'b0, 1'b0, 10);
        put(1'b0, 1'b1, 1);
        put(1'b0, 1'b0, 50);
        put_pixel(24'hDEAD42);
        put(1'b0, 1'b0, 1400);

        build_model();

        for (int unsigned t = 0; t < n_drv + LAT + 4; t++) begin
            @(posedge Clock);
            #1;
            ws_in = (t < n_drv) ? stim_line[t] : 1'b0;
            rst   = (t < n_drv) ? stim_rst[t]  : 1'b0;
            @(negedge Clock);
            if (e_rst[t]) begin
                h_grb = '0; h_idx = '0; h_busy = 1'b0;
            end
            if (e_pv[t]) begin
                h_grb = e_grb[t]; h_idx = e_idx[t];
            end
            if (e_on[t])  h_busy = 1'b1;
            if (e_off[t]) h_busy = 1'b0;
            exp_v = {e_pv[t], h_grb, h_idx, e_fe[t], e_err[t], h_busy};
            got_v = {pixel_valid, Green, Red, Blue, pixel_idx, frame_end, err, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL out_vec cycle=%0d got=%h exp=%h", t, got_v, exp_v);
            end
            if (t == 0) check("reset_state", 64'(got_v), 64'd0);
            if (pixel_valid === 1'b1) begin
                p.cyc = t; p.grb = {Green, Red, Blue}; p.idx = pixel_idx;
                got_q.push_back(p);
            end
            if (frame_end === 1'b1) fe_q.push_back(t);
            if (err === 1'b1) err_q.push_back(t);
            if (err === 1'b1 && frame_end === 1'b1) both_cnt++;
        end

        check("pixel_count", 64'(got_q.size()), 64'(N_PIX));
        for (int unsigned i = 0; i < N_PIX; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("pixel%0d", i), {30'd0, got_q[i].idx, got_q[i].grb},
                      {30'd0, IDX_W'(lit_idx[i]), lit_grb[i]});
            end else begin
                check($sformatf("pixel%0d_missing", i), 64'(got_q.size()), 64'(i + 1));
            end
        end
        check("frame_end_count", 64'(fe_q.size()), 64'd7);
        check("err_count", 64'(err_q.size()), 64'd3);
        check("err_with_frame_end", 64'(both_cnt), 64'd1);
        if (fe_q.size() > 0 && got_q.size() > 0) begin
            check("latch_delay", 64'(fe_q[0] - got_q[0].cyc), 64'(RESET_CNT));
        end else begin
            check("latch_delay_missing", 64'(fe_q.size() * got_q.size()), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
